// File: rtl/nap_timer_bcd.sv
// Countdown nap timer (MM:SS, four BCD digits) with a multiplexed BCD digit bus for a 7-segment decoder.
// Optional macro NAP_BLINK_EN: blanks the digits at 2 Hz while paused or done.
module nap_timer_bcd #(
   parameter int TICK_DIV    = 50000000,
   parameter int SCAN_DIV    = 50000,
   parameter int DEFAULT_MIN = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       min_inc,
   output logic [3:0] bNum,
   output logic [3:0] digit_sel,
   output logic       running,
   output logic       alarm
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_TC  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV - 1);
   localparam logic [3:0]    DEF_MT  = 4'(DEFAULT_MIN / 10);
   localparam logic [3:0]    DEF_MO  = 4'(DEFAULT_MIN % 10);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t        state, state_n;
   logic [3:0]    preset_mt, preset_mo;
   logic [7:0]    preset_n;
   logic [3:0]    cnt_mt, cnt_mo, cnt_st, cnt_so;
   logic [15:0]   count, count_dec, cnt_n;
   logic [PW-1:0] presc, presc_n;
   logic [SW-1:0] scan_cnt, scan_cnt_n;
   logic [1:0]    scan_idx, scan_idx_n;
   logic [3:0]    bnum_n;
   logic          tick, blank_n;

   // One-second BCD decrement with borrow; 00:00 is a fixed point.
   function automatic logic [15:0] bcd_dec(input logic [15:0] c);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = c;
      if (c != 16'h0000) begin
         if (so != 4'd0) so = so - 4'd1;
         else begin
            so = 4'd9;
            if (st != 4'd0) st = st - 4'd1;
            else begin
               st = 4'd5;
               if (mo != 4'd0) mo = mo - 4'd1;
               else begin
                  mo = 4'd9;
                  mt = mt - 4'd1;
               end
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] m);
      logic [3:0] t, o;
      {t, o} = m;
      if (o == 4'd9) begin
         o = 4'd0;
         t = (t == 4'd9) ? 4'd0 : t + 4'd1;
      end else begin
         o = o + 4'd1;
      end
      return {t, o};
   endfunction

   assign count     = {cnt_mt, cnt_mo, cnt_st, cnt_so};
   assign count_dec = bcd_dec(count);
   assign tick      = (state == S_RUN) && (presc == PRE_TC);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_n  = state;
      preset_n = {preset_mt, preset_mo};
      cnt_n    = count;
      presc_n  = presc;
      case (state)
         S_IDLE: begin
            presc_n = '0;
            if (min_inc) preset_n = bcd_inc({preset_mt, preset_mo});
            cnt_n = {preset_n, 8'h00};
            if (start && !stop) state_n = (preset_n == 8'h00) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            presc_n = tick ? '0 : presc + 1'b1;
            if (tick) cnt_n = count_dec;
            if (tick && count_dec == 16'h0000) state_n = S_DONE;
            else if (stop)                     state_n = S_PAUSE;
         end
         S_PAUSE: begin
            if (stop) begin
               state_n = S_IDLE;
               cnt_n   = {preset_mt, preset_mo, 8'h00};
            end else if (start) begin
               state_n = S_RUN;
            end
         end
         S_DONE: begin
            if (start || stop) begin
               state_n = S_IDLE;
               cnt_n   = {preset_mt, preset_mo, 8'h00};
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      scan_cnt_n = (scan_cnt == SCAN_TC) ? '0 : scan_cnt + 1'b1;
      scan_idx_n = (scan_cnt == SCAN_TC) ? scan_idx + 2'd1 : scan_idx;
      bnum_n     = blank_n ? 4'hF : cnt_n[scan_idx_n*4 +: 4];
   end

`ifdef NAP_BLINK_EN
   localparam int BD = (TICK_DIV / 4 > 1) ? TICK_DIV / 4 : 1;
   localparam int BW = (BD > 1) ? $clog2(BD) : 1;
   localparam logic [BW-1:0] BLINK_TC = BW'(BD - 1);

   logic [BW-1:0] blink_cnt;
   logic          blink_ph, blink_ph_n;

   assign blink_ph_n = (blink_cnt == BLINK_TC) ? ~blink_ph : blink_ph;
   assign blank_n    = blink_ph_n && (state_n == S_PAUSE || state_n == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else begin
         blink_cnt <= (blink_cnt == BLINK_TC) ? '0 : blink_cnt + 1'b1;
         blink_ph  <= blink_ph_n;
      end
   end
`else
   assign blank_n = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         preset_mt <= DEF_MT;
         preset_mo <= DEF_MO;
         cnt_mt    <= DEF_MT;
         cnt_mo    <= DEF_MO;
         cnt_st    <= 4'd0;
         cnt_so    <= 4'd0;
         presc     <= '0;
         scan_cnt  <= '0;
         scan_idx  <= 2'd0;
         digit_sel <= 4'b0001;
         bNum      <= 4'd0;
         running   <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         state     <= state_n;
         {preset_mt, preset_mo}         <= preset_n;
         {cnt_mt, cnt_mo, cnt_st, cnt_so} <= cnt_n;
         presc     <= presc_n;
         scan_cnt  <= scan_cnt_n;
         scan_idx  <= scan_idx_n;
         digit_sel <= 4'b0001 << scan_idx_n;
         bNum      <= bnum_n;
         running   <= (state_n == S_RUN);
         alarm     <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_nap_timer_bcd.sv
// Scoreboard bench for nap_timer_bcd (TICK_DIV=4, SCAN_DIV=2, DEFAULT_MIN=1); define NAP_BLINK_EN to cover blanking.
module tb_nap_timer_bcd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, min_inc = 1'b0;
   logic [3:0] bNum, digit_sel;
   logic       running, alarm;

   nap_timer_bcd #(.TICK_DIV(4), .SCAN_DIV(2), .DEFAULT_MIN(1)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .min_inc(min_inc),
      .bNum(bNum), .digit_sel(digit_sel), .running(running), .alarm(alarm)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          cyc;
      logic [15:0] cnt;
      logic        run;
      logic        alm;
      logic        frz;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc;

   // Clock edges since reset release; the scan slot and blink phase follow from it.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Monitor: the DUT presents a fresh display slot every cycle; compare against queued expectations.
   exp_t       e;
   int         idx;
   logic [3:0] exp_b;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         if (e.cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: expectation for cycle %0d not checked, now %0d", e.name, e.cyc, cyc);
         end else begin
            idx   = (cyc / 2) % 4;
            exp_b = e.cnt[idx*4 +: 4];
`ifdef NAP_BLINK_EN
            if ((e.frz || e.alm) && (cyc % 2 == 1)) exp_b = 4'hF;
`endif
            check({e.name, ".count"},     {dut.cnt_mt, dut.cnt_mo, dut.cnt_st, dut.cnt_so}, e.cnt);
            check({e.name, ".digit_sel"}, {12'h0, digit_sel}, 16'(4'b0001 << idx));
            check({e.name, ".bNum"},      {12'h0, bNum}, {12'h0, exp_b});
            check({e.name, ".running"},   {15'h0, running}, {15'h0, e.run});
            check({e.name, ".alarm"},     {15'h0, alarm}, {15'h0, e.alm});
         end
      end
   end

   task automatic expect_now(input string nm, input int m, input int s,
                             input logic run, input logic alm, input logic frz);
      exp_t x;
      x.name = nm;
      x.cyc  = cyc;
      x.cnt  = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
      x.run  = run;
      x.alm  = alm;
      x.frz  = frz;
      q.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic s, input logic p, input logic m);
      start = s; stop = p; min_inc = m;
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; min_inc = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1 rst = 1'b0;
      expect_now("reset", 1, 0, 0, 0, 0);
      for (int i = 1; i < 8; i++) begin
         step(1);
         expect_now("scan", 1, 0, 0, 0, 0);
      end

      // Full countdown 01:00 -> 00:00
      pulse(1, 0, 0);               expect_now("start", 1, 0, 1, 0, 0);
      step(3);                      expect_now("pre_tick", 1, 0, 1, 0, 0);
      step(1);                      expect_now("tick1", 0, 59, 1, 0, 0);
      for (int t = 1; t <= 58; t++) begin
         step(4);
         expect_now("countdown", 0, 59 - t, 1, 0, 0);
      end
      step(3);                      expect_now("last_sec", 0, 1, 1, 0, 0);
      step(1);                      expect_now("done", 0, 0, 0, 1, 0);
      step(4);                      expect_now("done_hold", 0, 0, 0, 1, 0);
      pulse(0, 1, 0);               expect_now("done_stop", 1, 0, 0, 0, 0);

      // Pause keeps count and prescaler
      pulse(1, 0, 0);
      step(2);
      pulse(0, 1, 0);               expect_now("pause", 1, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) begin
         step(1);
         expect_now("pause_hold", 1, 0, 0, 0, 1);
      end
      pulse(1, 0, 0);               expect_now("resume", 1, 0, 1, 0, 0);
      step(1);                      expect_now("resume_tick", 0, 59, 1, 0, 0);
      pulse(0, 1, 0);               expect_now("pause2", 0, 59, 0, 0, 1);
      pulse(0, 1, 0);               expect_now("abort", 1, 0, 0, 0, 0);

      // Tick and stop on the same edge
      pulse(1, 0, 0);
      step(3);
      pulse(0, 1, 0);               expect_now("tick_stop", 0, 59, 0, 0, 1);
      pulse(0, 1, 0);               expect_now("tick_stop_abort", 1, 0, 0, 0, 0);

      // min_inc ignored in RUN
      pulse(1, 0, 0);
      pulse(0, 0, 1);               expect_now("run_min_inc", 1, 0, 1, 0, 0);
      pulse(0, 1, 0);               expect_now("run_min_inc_p", 1, 0, 0, 0, 1);
      pulse(0, 1, 0);               expect_now("run_min_inc_i", 1, 0, 0, 0, 0);

      // start+stop together: stop wins
      pulse(1, 1, 0);               expect_now("ss_idle", 1, 0, 0, 0, 0);
      pulse(1, 0, 0);
      pulse(1, 1, 0);               expect_now("ss_run", 1, 0, 0, 0, 1);
      pulse(0, 1, 0);               expect_now("ss_abort", 1, 0, 0, 0, 0);

      // Preset increment, increment with start, wrap 99 -> 00
      pulse(0, 0, 1);               expect_now("min_inc", 2, 0, 0, 0, 0);
      pulse(1, 0, 1);               expect_now("inc_start", 3, 0, 1, 0, 0);
      pulse(0, 1, 0);               expect_now("inc_start_p", 3, 0, 0, 0, 1);
      pulse(0, 1, 0);               expect_now("inc_start_i", 3, 0, 0, 0, 0);
      for (int i = 0; i < 96; i++) pulse(0, 0, 1);
      expect_now("preset99", 99, 0, 0, 0, 0);
      pulse(0, 0, 1);               expect_now("wrap00", 0, 0, 0, 0, 0);
      pulse(1, 0, 0);               expect_now("zero_start", 0, 0, 0, 1, 0);
      pulse(0, 1, 0);               expect_now("zero_stop", 0, 0, 0, 0, 0);
      pulse(0, 0, 1);               expect_now("preset01", 1, 0, 0, 0, 0);
      pulse(0, 0, 1);               expect_now("preset02", 2, 0, 0, 0, 0);

      // Reset in the middle of a countdown
      pulse(1, 0, 0);               expect_now("run2", 2, 0, 1, 0, 0);
      step(332);                    expect_now("at_0037", 0, 37, 1, 0, 0);
      step(1);
      rst = 1'b1;
      #1;                           expect_now("mid_reset", 1, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;                expect_now("post_reset", 1, 0, 0, 0, 0);
      step(1);                      expect_now("post_reset1", 1, 0, 0, 0, 0);

      for (int i = 0; i < 4 && q.size() > 0; i++) step(1);
      if (q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nap_timer_bcd.md
Name: nap_timer_bcd

Overview:
Countdown nap timer, MM:SS, in four BCD digits; drives the 7-segment decoder stage.
Multiplexes the four digits onto one 4-bit BCD bus (bNum) with a one-hot digit select, one digit per scan slot.
The downstream decoder converts bNum to segments; digit_sel drives the display common lines.
Control pulses come from debounced user buttons elsewhere in the design.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s countdown tick (prescaler terminal count + 1); must be >= 2
SCAN_DIV, 50000, clk cycles per display digit slot; must be >= 1
DEFAULT_MIN, 20, preset minutes after reset, 0..99, stored as BCD

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle pulse; begin or resume countdown
stop  input  1  single-cycle pulse; pause when running, abort to IDLE otherwise
min_inc  input  1  single-cycle pulse; preset minutes +1 (IDLE only)
bNum  output  4  BCD value of currently scanned digit, to segment decoder
digit_sel  output  4  one-hot active digit: [3]=min tens, [2]=min ones, [1]=sec tens, [0]=sec ones
running  output  1  high in RUN
alarm  output  1  high in DONE

Behaviour:
- Reset (async, active-high): state=IDLE; preset=DEFAULT_MIN; count=DEFAULT_MIN:00; prescaler=0; scan counter=0; scan index=0; digit_sel=4'b0001; bNum=count sec-ones (0); running=0; alarm=0.
- Registers: preset_mt/preset_mo (BCD minutes), cnt_mt, cnt_mo, cnt_st (0..5), cnt_so (each 4-bit BCD).
- States:
  IDLE: count mirrors preset. min_inc: preset +1 BCD, 99 wraps to 00. start: -> RUN, prescaler cleared. start with count 00:00 -> DONE next cycle.
  RUN: prescaler counts 0..TICK_DIV-1; at terminal count, tick: count decrements by one second with BCD borrow (so 9->0 borrow, st 0->5 borrow, mo 0->9 borrow, mt-1). Tick producing 00:00 -> DONE same edge. stop -> PAUSE (prescaler held).
  PAUSE: count and prescaler frozen. start -> RUN, prescaler continues from held value. stop -> IDLE, count reloaded from preset.
  DONE: count holds 00:00, alarm=1. stop or start -> IDLE, count reloaded from preset.
- Simultaneous: start and stop in the same cycle -> stop wins. min_inc ignored outside IDLE. min_inc with start in IDLE: increment applies, state -> RUN with new count (count = incremented preset).
- Tick and stop in the same RUN cycle: decrement applies, then state -> PAUSE.
- Scan: scan counter 0..SCAN_DIV-1 runs in all states. At terminal count, index advances 0->1->2->3->0. digit_sel=1<<index.
- bNum is registered and updates on the same edge as digit_sel (no skew). Values come from live count.
- bNum is always 0..9 unless blanking (Optional Feature).
- running and alarm are registered decodes of state; no glitches.
- Prescaler width = clog2(TICK_DIV); scan counter width = clog2(SCAN_DIV). No overflow beyond terminal counts.

Optional Feature:
NAP_BLINK_EN: when defined, a 2 Hz blink phase toggles every TICK_DIV/4 clk cycles. The phase counter runs in all states and is cleared by reset.
- In PAUSE and DONE, bNum=4'hF (decoder blank) during the off phase; digit_sel keeps scanning.
- IDLE and RUN are unaffected.
When undefined, digits never blank and the blink phase logic is absent.

Test Plan:
- Reset with TICK_DIV=4, SCAN_DIV=2, DEFAULT_MIN=1 -> count 01:00, digit_sel=0001, bNum=0, running=0, alarm=0; scan order 0001,0010,0100,1000 every 2 clk, with bNum 0,0,1,0.
- start, run 4 clk -> 00:59; continue 59 ticks -> 00:00 and alarm=1 on that tick edge; running=0.
- RUN, stop -> PAUSE, count frozen 16 clk; start -> resumes, next tick after remaining prescaler cycles; stop, stop -> IDLE with count=01:00.
- IDLE, DEFAULT_MIN=99, min_inc -> preset 00; min_inc during RUN -> no change.
- start and stop pulsed in the same cycle from IDLE -> stays IDLE. In RUN -> PAUSE. Assert rst mid-RUN at 00:37 -> immediately IDLE, 01:00, outputs at reset values.
- NAP_BLINK_EN defined, PAUSE -> bNum alternates digit value / 4'hF with 2 clk period; RUN -> no 4'hF ever.
